// File: rtl/ddr3_ctrl_pkg.sv
// ddr3_ctrl_pkg: shared FSM encoding, widths and burst-length helper for the DDR3 controller slice
package ddr3_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, DONE = 2'd3} rd_state_e;
  localparam int CMD_LEN_W = 16;
  localparam int OPS_W = 32;
  // Zero-beat bursts are issued as single-beat bursts.
  function automatic logic [CMD_LEN_W-1:0] burst_to_len(input logic [15:0] b);
    return (b == 16'd0) ? 16'd0 : b - 16'd1;
  endfunction
endpackage

// File: rtl/ddr3_rd_cmd_sequencer.sv
// ddr3_rd_cmd_sequencer: expands one read descriptor into strided burst commands with an in-flight cap.
// Optional DDR3_RD_PERF_CNT_EN adds stall_cycles and beat_count outputs.
module ddr3_rd_cmd_sequencer
  import ddr3_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 33,
  parameter int MAX_OUTSTANDING = 8,
  parameter int OUT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [31:0]           cfg_ops,
  input  logic [31:0]           cfg_stride,
  input  logic [ADDR_WIDTH-1:0] cfg_init_addr,
  input  logic [15:0]           cfg_burst_size,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic [15:0]           cmd_len,
  input  logic                  rd_valid,
  input  logic                  rd_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err_unexpected
`ifdef DDR3_RD_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           beat_count
`endif
);
  localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);
  rd_state_e state;
  logic [OPS_W-1:0] ops, issued, completed, issued_n, completed_n;
  logic [31:0] stride;
  logic [ADDR_WIDTH-1:0] addr_acc;
  logic [OUT_W-1:0] outstanding, outstanding_n;
  logic [CMD_LEN_W-1:0] len_r;
  logic hs, cpl, cpl_ok, cpl_bad, can_issue;
  assign cmd_addr = addr_acc;
  assign cmd_len = len_r;
  // A completion with nothing in flight is only legal when a handshake lands in the same cycle.
  always_comb begin
    hs = cmd_valid && cmd_ready;
    cpl = rd_valid && rd_last;
    cpl_ok = cpl && (outstanding != '0 || hs);
    cpl_bad = cpl && outstanding == '0 && !hs;
    issued_n = issued + OPS_W'(hs);
    completed_n = completed + OPS_W'(cpl_ok);
    outstanding_n = (hs && !cpl) ? outstanding + OUT_W'(1) :
                    (cpl_ok && !hs) ? outstanding - OUT_W'(1) : outstanding;
    can_issue = issued_n < ops && outstanding_n < MAX_OUT;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ops <= '0;
      stride <= '0;
      addr_acc <= '0;
      len_r <= '0;
      issued <= '0;
      completed <= '0;
      outstanding <= '0;
      cmd_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err_unexpected <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cpl_bad) err_unexpected <= 1'b1;
      case (state)
        IDLE: if (start) begin
          ops <= cfg_ops;
          stride <= cfg_stride;
          addr_acc <= cfg_init_addr;
          len_r <= burst_to_len(cfg_burst_size);
          issued <= '0;
          completed <= '0;
          outstanding <= '0;
          err_unexpected <= 1'b0;
          busy <= 1'b1;
          state <= (cfg_ops == '0) ? DONE : ISSUE;
        end
        ISSUE, DRAIN: begin
          issued <= issued_n;
          completed <= completed_n;
          outstanding <= outstanding_n;
          if (hs) addr_acc <= addr_acc + ADDR_WIDTH'(stride);
          // A raised command holds until accepted; the cap is only checked before raising.
          if (!cmd_valid || cmd_ready) cmd_valid <= state == ISSUE && can_issue;
          if (state == ISSUE && hs && issued_n == ops) state <= DRAIN;
          if (state == DRAIN && completed_n == ops) state <= DONE;
        end
        DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef DDR3_RD_PERF_CNT_EN
  logic active;
  assign active = state == ISSUE || state == DRAIN;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      beat_count <= '0;
    end else if (state == IDLE && start) begin
      stall_cycles <= '0;
      beat_count <= '0;
    end else if (active) begin
      if (cmd_valid && !cmd_ready && stall_cycles != 32'hFFFF_FFFF) stall_cycles <= stall_cycles + 32'd1;
      if (rd_valid) beat_count <= beat_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_ddr3_rd_cmd_sequencer.sv
// tb_ddr3_rd_cmd_sequencer: directed self-checking bench for the DDR3 read command sequencer.
module tb_ddr3_rd_cmd_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [31:0] cfg_ops = '0, cfg_stride = '0;
  logic [32:0] cfg_init_addr = '0;
  logic [15:0] cfg_burst_size = '0;
  logic cmd_valid, cmd_ready = 1'b0;
  logic [32:0] cmd_addr;
  logic [15:0] cmd_len;
  logic rd_valid = 1'b0, rd_last = 1'b0;
  logic busy, done, err_unexpected;
`ifdef DDR3_RD_PERF_CNT_EN
  logic [31:0] stall_cycles, beat_count;
`endif
  int total = 0, bad = 0, nvalid;
  ddr3_rd_cmd_sequencer #(.ADDR_WIDTH(33), .MAX_OUTSTANDING(8), .OUT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_ops(cfg_ops), .cfg_stride(cfg_stride), .cfg_init_addr(cfg_init_addr), .cfg_burst_size(cfg_burst_size),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .rd_valid(rd_valid), .rd_last(rd_last),
    .busy(busy), .done(done), .err_unexpected(err_unexpected)
`ifdef DDR3_RD_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .beat_count(beat_count)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic go(input logic [31:0] o, input logic [31:0] s, input logic [32:0] a, input logic [15:0] b);
    cfg_ops = o;
    cfg_stride = s;
    cfg_init_addr = a;
    cfg_burst_size = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic cpl;
    rd_valid = 1'b1;
    rd_last = 1'b1;
    tick();
    rd_valid = 1'b0;
    rd_last = 1'b0;
  endtask
  initial begin
    tick();
    tick();
    chk("rst_valid", cmd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_unexpected, 0);
    chk("rst_addr", cmd_addr, 0);
    chk("rst_len", cmd_len, 0);
    rst_n = 1'b1;
    tick();
    // four back-to-back strided bursts, then 16 beats returned per burst
    cmd_ready = 1'b1;
    go(4, 32'h100, 33'h1000, 16);
    chk("t1_busy", busy, 1);
    chk("t1_valid_lat", cmd_valid, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t1_valid", cmd_valid, 1);
      chk("t1_addr", cmd_addr, 64'h1000 + 64'(k) * 64'h100);
      chk("t1_len", cmd_len, 15);
    end
    tick();
    chk("t1_valid_end", cmd_valid, 0);
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 16; i++) begin
        rd_valid = 1'b1;
        rd_last = (i == 15);
        tick();
        if (i == 15) chk("t1_no_early_done", done, 0);
      end
    rd_valid = 1'b0;
    rd_last = 1'b0;
    chk("t1_busy_drain", busy, 1);
    tick();
    chk("t1_done", done, 1);
    chk("t1_busy_off", busy, 0);
    tick();
    chk("t1_done_pulse", done, 0);
    chk("t1_err", err_unexpected, 0);
`ifdef DDR3_RD_PERF_CNT_EN
    chk("t1_beats", beat_count, 64);
    chk("t1_stall", stall_cycles, 0);
`endif
    // in-flight cap of 8 with 12 ops
    go(12, 32'h40, 33'h2000, 0);
    nvalid = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (i == 0) chk("t2_len0", cmd_len, 0);
      nvalid += int'(cmd_valid);
    end
    chk("t2_cap", nvalid, 8);
    chk("t2_valid_blocked", cmd_valid, 0);
    for (int k = 8; k < 12; k++) begin
      cpl();
      chk("t2_release", cmd_valid, 1);
      chk("t2_addr", cmd_addr, 64'h2000 + 64'(k) * 64'h40);
      tick();
      chk("t2_reblock", cmd_valid, 0);
    end
    for (int i = 0; i < 8; i++) begin
      rd_valid = 1'b1;
      rd_last = 1'b1;
      tick();
    end
    rd_valid = 1'b0;
    rd_last = 1'b0;
    chk("t2_no_early_done", done, 0);
    tick();
    chk("t2_done", done, 1);
    chk("t2_err", err_unexpected, 0);
    // back-pressure: command must hold; a start while busy is ignored
    cmd_ready = 1'b0;
    go(1, 32'h10, 33'h3000, 4);
    tick();
    chk("t3_valid", cmd_valid, 1);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) go(3, 32'h1, 33'h7777, 9);
      else tick();
      chk("t3_hold_valid", cmd_valid, 1);
      chk("t3_hold_addr", cmd_addr, 64'h3000);
      chk("t3_hold_len", cmd_len, 3);
    end
    cmd_ready = 1'b1;
    tick();
    chk("t3_accepted", cmd_valid, 0);
`ifdef DDR3_RD_PERF_CNT_EN
    chk("t3_stall", stall_cycles, 6);
`endif
    cpl();
    tick();
    chk("t3_done", done, 1);
`ifdef DDR3_RD_PERF_CNT_EN
    chk("t3_beats", beat_count, 1);
`endif
    // address wraps modulo 2^33
    go(2, 32'h200, 33'h1_FFFF_FF00, 8);
    tick();
    chk("t4_addr0", cmd_addr, 64'h1_FFFF_FF00);
    tick();
    chk("t4_valid1", cmd_valid, 1);
    chk("t4_addr_wrap", cmd_addr, 64'h100);
    tick();
    chk("t4_valid_end", cmd_valid, 0);
    cpl();
    cpl();
    tick();
    chk("t4_done", done, 1);
    // zero-op descriptor, then a completion with nothing outstanding
    go(0, 32'h10, 33'h9000, 4);
    chk("t5_busy", busy, 1);
    chk("t5_valid", cmd_valid, 0);
    chk("t5_done_early", done, 0);
    tick();
    chk("t5_done", done, 1);
    chk("t5_busy_off", busy, 0);
    chk("t5_valid2", cmd_valid, 0);
    tick();
    chk("t5_done_pulse", done, 0);
    cpl();
    chk("t5_err", err_unexpected, 1);
    tick();
    tick();
    chk("t5_err_sticky", err_unexpected, 1);
    // reset mid-descriptor, then a fresh single-op descriptor
    go(5, 32'h80, 33'h4000, 8);
    chk("t6_err_clear", err_unexpected, 0);
    tick();
    tick();
    chk("t6_second", cmd_addr, 64'h4080);
    tick();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", cmd_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_addr", cmd_addr, 0);
    chk("t6_rst_len", cmd_len, 0);
    tick();
    chk("t6_rst_done", done, 0);
    chk("t6_rst_err", err_unexpected, 0);
    rst_n = 1'b1;
    tick();
    go(1, 32'h10, 33'h5000, 8);
    tick();
    chk("t6_valid", cmd_valid, 1);
    chk("t6_addr", cmd_addr, 64'h5000);
    chk("t6_len", cmd_len, 7);
    tick();
    chk("t6_valid_end", cmd_valid, 0);
    cpl();
    chk("t6_no_early_done", done, 0);
    tick();
    chk("t6_done", done, 1);
    tick();
    chk("t6_done_pulse", done, 0);
    chk("t6_busy", busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
